fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO's write port among `N_REQ` producers. Each producer uses a valid/ready handshake. The arbiter grants bounded bursts and drives registered `fifo_write`/`fifo_data_in` into the FIFO. It tracks FIFO occupancy with an internal credit counter, so the FIFO's one-cycle-late `fifo_full` flag is never needed and the FIFO can never overflow.

## Interface
- `N_REQ`, 4: number of requesters (≥2)
- `width`, 16: data word width
- `depth`, 16: downstream FIFO depth (power of 2); initial credit count
- `MAX_BURST`, 4: maximum consecutive transfers per grant (≥1)

- `clk`  in  1  single clock, rising edge
- `rst_`  in  1  asynchronous, active-low reset
- `req_valid`  in  N_REQ  requester i has a word
- `req_data`  in  N_REQ*width  requester i word at `[i*width +: width]`
- `req_ready`  out  N_REQ  requester i word accepted this cycle if `req_valid[i]` is also high
- `fifo_pop`  in  1  one-cycle pulse per word actually read from the FIFO
- `fifo_write`  out  1  registered write strobe to the FIFO
- `fifo_data_in`  out  width  registered write data to the FIFO
- `grant_id`  out  $clog2(N_REQ)  current owner; valid while `busy`
- `busy`  out  1  state == BURST
- `credit_err`  out  1  sticky; `fifo_pop` arrived while credits == `depth`

## Operation
- Credits: counter of width $clog2(depth)+1, reset value `depth`. Each cycle: credits <= credits − xfer + `fifo_pop`. A simultaneous xfer and pop leaves credits unchanged. A pop at credits == `depth` is ignored and sets `credit_err`, which is cleared only by reset.
- xfer = `req_valid[owner] && req_ready[owner]`.
- FSM states: IDLE, BURST. Reset state is IDLE.
  - IDLE:
    - `req_ready` = 0.
    - If any `req_valid` is high, owner <= first i with `req_valid[i]` set, searching i = rr_ptr, rr_ptr+1, … mod N_REQ.
    - In that case burst_cnt <= 0 and the FSM moves to BURST. Otherwise it stays in IDLE.
  - BURST:
    - `req_ready[owner]` = (credits != 0). All other `req_ready` bits are 0.
    - On xfer, burst_cnt increments.
    - Exit to IDLE on either condition:
      - xfer with burst_cnt == MAX_BURST−1, or
      - `req_valid[owner]` == 0 (no transfer that cycle).
    - On exit, rr_ptr <= (owner+1) mod N_REQ.
    - With credits == 0 the FSM stays in BURST with ready low. Grant is held and burst_cnt is frozen until a pop returns a credit.
- Output register: `fifo_write` <= xfer; `fifo_data_in` <= owner's data on xfer, otherwise holds its value.
- `req_ready` is combinational from state, owner and credits only. There is no combinational path from `req_valid`.
- rr_ptr reset value is 0. owner and burst_cnt reset to 0.

## Timing
- Reset values: `fifo_write` 0, `fifo_data_in` 0, `req_ready` all 0, `grant_id` 0, `busy` 0, `credit_err` 0, credits = `depth`.
- Arbitration takes one cycle: valid seen in IDLE → grant registered → first xfer in the following cycle at the earliest.
- Write latency is 1: xfer at cycle t gives `fifo_write`=1 with the matching data at cycle t+1.
- Streaming owner: one word per cycle for up to MAX_BURST cycles, then one IDLE cycle before the next grant.
- Credit reaches 0 on the depth-th outstanding write. `req_ready` drops in the same cycle credits become 0, and never sequences a write into a full FIFO. A pop at t makes ready high at t+1.
- Reset asserted mid-burst: all state returns to reset values immediately (async). A pending registered write is dropped. No `fifo_write` is issued while `rst_`=0.

## Test plan
- Single requester 0, valid held, 6 words 0x0001..0x0006, MAX_BURST=4:
  - words 1–4 appear on `fifo_write` in consecutive cycles, then one gap cycle;
  - words 5–6 follow after re-grant.
- All 4 requesters valid continuously:
  - grant order 0,1,2,3,0;
  - each burst is exactly 4 writes;
  - `grant_id` tracks the owner.
- No pops, requester 2 streams 20 words with depth=16:
  - exactly 16 writes, then `req_ready`=0 while `busy` stays 1;
  - one `fifo_pop` pulse → exactly one more write 2 cycles later.
- Requester 1 drops `req_valid` after 2 words: FSM returns to IDLE and the next grant goes to requester 2 (if valid) before 0.
- Pop and xfer in the same cycle at credits=1: credits stay 1 and ready remains high.
- `fifo_pop` at reset (credits=16) → `credit_err`=1 and credits stay 16.
- `rst_` low mid-burst → `fifo_write`=0 and `busy`=0 at once; after release credits=16 and the first grant goes to requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//
// Round-robin write arbiter sharing one synchronous FIFO write port among
// N_REQ valid/ready producers. A grant lasts for at most MAX_BURST words.
// FIFO occupancy is tracked with an internal credit counter, so the FIFO's
// late full flag is not needed and the FIFO cannot overflow.
//
// Ports:
//   clk          rising-edge clock
//   rst_         asynchronous active-low reset
//   req_valid    per-requester "word available"
//   req_data     per-requester word, requester i at [i*width +: width]
//   req_ready    per-requester accept (only the owner, only with credit)
//   fifo_pop     one pulse per word read out of the downstream FIFO
//   fifo_write   registered FIFO write strobe
//   fifo_data_in registered FIFO write data (holds between writes)
//   grant_id     current owner, meaningful while busy
//   busy         a grant is active
//   credit_err   sticky: a pop arrived while no word was outstanding
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int width     = 16,
  parameter int depth     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*width-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     fifo_pop,
  output logic                     fifo_write,
  output logic [width-1:0]         fifo_data_in,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     credit_err
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(depth) + 1;
  localparam int BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [IDW-1:0]   owner;
  logic [IDW-1:0]   rr_ptr;
  logic [BW-1:0]    burst_cnt;
  logic [CW-1:0]    credits;

  logic             has_credit;
  logic             xfer;
  logic             owner_valid;
  logic             burst_last;
  logic [IDW-1:0]   next_owner;
  logic [IDW-1:0]   owner_plus1;
  logic [CW-1:0]    xfer_ext;
  logic [CW-1:0]    pop_ext;
  logic [width-1:0] req_word [N_REQ];

  // Unpack the flat data bus into one word per requester.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*width +: width];
    end
  endgenerate

  assign has_credit  = (credits != '0);
  assign owner_valid = req_valid[owner];

  // Ready depends only on registered state, never on req_valid.
  always_comb begin
    req_ready = '0;
    if (state == BURST && has_credit)
      req_ready[owner] = 1'b1;
  end

  assign xfer        = owner_valid && req_ready[owner];
  assign burst_last  = (burst_cnt == BW'(MAX_BURST - 1));
  assign owner_plus1 = (owner == IDW'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign xfer_ext    = {{(CW-1){1'b0}}, xfer};
  assign pop_ext     = {{(CW-1){1'b0}}, fifo_pop};

  // Round-robin search starting at rr_ptr. Scanning from the farthest
  // candidate back to rr_ptr lets the nearest valid requester win.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    next_owner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx  = (int'(rr_ptr) + k) % N_REQ;
      cand = idx[IDW-1:0];
      if (req_valid[cand])
        next_owner = cand;
    end
  end

  // Credit counter: a pop with nothing outstanding is dropped and flagged.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      credits    <= CW'(depth);
      credit_err <= 1'b0;
    end else if (fifo_pop && credits == CW'(depth)) begin
      credits    <= credits - xfer_ext;
      credit_err <= 1'b1;
    end else begin
      credits    <= credits - xfer_ext + pop_ext;
    end
  end

  // Grant FSM. With zero credits the owner keeps the grant and burst_cnt
  // stays frozen, because xfer cannot happen and valid is still high.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner     <= next_owner;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_last) begin
              state  <= IDLE;
              rr_ptr <= owner_plus1;
            end
          end else if (!owner_valid) begin
            state  <= IDLE;
            rr_ptr <= owner_plus1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered write port toward the FIFO.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      fifo_write   <= 1'b0;
      fifo_data_in <= '0;
    end else begin
      fifo_write <= xfer;
      if (xfer)
        fifo_data_in <= req_word[owner];
    end
  end

  assign grant_id = owner;
  assign busy     = (state == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: randomized and scenario-driven stimulus
// compared every cycle against a behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst_ = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic             fifo_pop = 1'b0;
  logic             fifo_write;
  logic [W-1:0]     fifo_data_in;
  logic [1:0]       grant_id;
  logic             busy;
  logic             credit_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (register contents after the last clock edge).
  bit         m_busy;
  int         m_owner;
  int         m_cnt;
  int         m_credits;
  int         m_rr;
  bit         m_err;
  bit         m_wr;
  logic [W-1:0] m_data;

  fifo_wr_arbiter #(.N_REQ(N), .width(W), .depth(D), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst_         (rst_),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_pop     (fifo_pop),
    .fifo_write   (fifo_write),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cnt = 0; m_credits = D;
    m_rr = 0; m_err = 0; m_wr = 0; m_data = '0;
  endtask

  // One clock edge of the arbitration rules, using the inputs now applied.
  task automatic model_advance();
    int  xf;
    bit  found;
    xf = (m_busy && m_credits != 0 && req_valid[m_owner]) ? 1 : 0;
    if (fifo_pop && m_credits == D) begin
      m_err = 1;
      m_credits = m_credits - xf;
    end else begin
      m_credits = m_credits - xf + int'(fifo_pop);
    end
    m_wr = (xf != 0);
    if (xf != 0) m_data = req_data[m_owner*W +: W];
    if (!m_busy) begin
      if (req_valid != '0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && req_valid[(m_rr + k) % N]) begin
            m_owner = (m_rr + k) % N;
            found = 1;
          end
        end
        m_cnt = 0;
        m_busy = 1;
      end
    end else if (xf != 0) begin
      if (m_cnt == MB - 1) begin
        m_busy = 0;
        m_rr = (m_owner + 1) % N;
      end else begin
        m_cnt++;
      end
    end else if (!req_valid[m_owner]) begin
      m_busy = 0;
      m_rr = (m_owner + 1) % N;
    end
  endtask

  task automatic compare();
    logic [N-1:0] exp_ready;
    exp_ready = '0;
    if (m_busy && m_credits != 0) exp_ready[m_owner] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("fifo_write", 64'(fifo_write), 64'(m_wr));
    check("fifo_data_in", 64'(fifo_data_in), 64'(m_data));
    check("busy", 64'(busy), 64'(m_busy));
    if (m_busy) check("grant_id", 64'(grant_id), 64'(m_owner));
    check("credit_err", 64'(credit_err), 64'(m_err));
  endtask

  // Check the current outputs, apply new inputs, advance the model.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic p);
    @(negedge clk);
    compare();
    req_valid = v;
    req_data  = d;
    fifo_pop  = p;
    model_advance();
  endtask

  // Assert reset at a falling edge, check the async effect, release later.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    model_reset();
    check("rst_async_write", 64'(fifo_write), 64'(0));
    check("rst_async_busy", 64'(busy), 64'(0));
    compare();
    repeat (cycles) begin
      @(negedge clk);
      compare();
    end
    rst_ = 1'b1;
    model_advance();
  endtask

  // mode 0: random valids/pops, 1: req0 only, 2: all valid,
  // 3: req2 only without pops, 4: no valids, drain pops.
  task automatic run(input int mode, input int cycles);
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic           p;
    for (int c = 0; c < cycles; c++) begin
      d = {$urandom, $urandom};
      p = (m_credits < D) && ($urandom_range(0, 1) == 0);
      case (mode)
        0: v = N'($urandom);
        1: v = 4'b0001;
        2: v = 4'b1111;
        3: begin v = 4'b0100; p = 1'b0; end
        default: begin v = '0; p = (m_credits < D); end
      endcase
      step(v, d, p);
    end
  endtask

  initial begin
    model_reset();
    do_reset(3);

    // Pop with nothing outstanding: sticky error, cleared only by reset.
    step('0, '0, 1'b1);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    do_reset(2);

    run(1, 12);
    run(4, 4);
    run(2, 24);
    run(4, 20);

    // Starve credits: requester 2 fills the FIFO, then one pop frees one slot.
    run(3, 25);
    step(4'b0100, {$urandom, $urandom}, 1'b1);
    run(3, 5);
    run(4, 20);

    // Requester 1 stops after two words; requesters 0 and 2 both waiting.
    step(4'b0010, {$urandom, $urandom}, 1'b0);
    step(4'b0010, {$urandom, $urandom}, 1'b0);
    step(4'b0010, {$urandom, $urandom}, 1'b0);
    step(4'b0101, {$urandom, $urandom}, 1'b0);
    run(2, 12);
    run(4, 20);

    run(0, 400);

    // Reset in the middle of an all-valid burst.
    run(2, 3);
    do_reset(2);
    run(2, 10);
    run(0, 400);

    @(negedge clk);
    compare();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
